// File: rtl/delay_timer_multi.sv
// Multi-channel programmable delay timer: each channel latches a delay on start
// and emits a registered one-cycle done pulse, one-shot or periodic, abortable.
module delay_timer_multi #(
  parameter int DELAY_W = 7,
  parameter int N_CH    = 4
) (
  input  logic                    i_clk,
  input  logic                    i_arst,
  input  logic [N_CH*DELAY_W-1:0] i_delay,
  input  logic [N_CH-1:0]         i_start,
  input  logic [N_CH-1:0]         i_abort,
  input  logic [N_CH-1:0]         i_periodic,
  output logic [N_CH-1:0]         o_busy,
  output logic [N_CH-1:0]         o_done,
  output logic                    o_anyDone
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } state_e;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    state_e               state_q;
    logic [DELAY_W-1:0]   delay_q;
    logic [DELAY_W-1:0]   cnt_q;
    logic                 mode_q;
    logic                 done_q;

    // Priority: abort beats start beats expiry. Expiry is checked on equality,
    // so the counter never needs to wrap even at the full-range delay.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // channel samples its inputs and its own state from before the edge.
    always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
        state_q <= S_IDLE;
        delay_q <= '0;
        cnt_q   <= '0;
        mode_q  <= 1'b0;
        done_q  <= 1'b0;
      end else if (i_abort[c]) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        done_q  <= 1'b0;
      end else if (i_start[c]) begin
        state_q <= S_COUNT;
        delay_q <= i_delay[c*DELAY_W +: DELAY_W];
        mode_q  <= i_periodic[c];
        cnt_q   <= '0;
        done_q  <= 1'b0;
      end else if (state_q == S_COUNT) begin
        if (cnt_q == delay_q) begin
          done_q <= 1'b1;
          cnt_q  <= '0;
          if (!mode_q) begin
            state_q <= S_IDLE;
          end
        end else begin
          done_q <= 1'b0;
          cnt_q  <= cnt_q + 1'b1;
        end
      end else begin
        done_q <= 1'b0;
      end
    end

    assign o_busy[c] = (state_q == S_COUNT);
    assign o_done[c] = done_q;
  end

  assign o_anyDone = |o_done;

endmodule
